// File: rtl/necpu_pkg.sv
// Shared NECPU types: bus widths, fetch FSM states and the fetch queue entry layout.
package necpu_pkg;

  localparam int unsigned InstBusWidth = 32;
  localparam int unsigned InstAddrBus  = 32;

  typedef enum logic {
    IDLE,
    RUN
  } fetch_state_e;

  typedef struct packed {
    logic [InstAddrBus-1:0]  pc;
    logic [InstBusWidth-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO for fetched {pc, inst} entries, with flush and push-while-full-on-pop.
module fetch_queue #(
  parameter int unsigned  Width = 64,
  parameter int unsigned  Depth = 2,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count_q < CntW'(Depth)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads instMem combinationally, queues
// {pc, inst} pairs and hands them to decode; execute can redirect or halt it.
module fetch_unit #(
  parameter int unsigned            InstBusWidth = necpu_pkg::InstBusWidth,
  parameter int unsigned            InstAddrBus  = necpu_pkg::InstAddrBus,
  parameter int unsigned            QDEPTH       = 2,
  parameter logic [InstAddrBus-1:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    halt,
  input  logic                    redirect_valid,
  input  logic [InstAddrBus-1:0]  redirect_pc,
  output logic [InstAddrBus-1:0]  imem_addr,
  input  logic [InstBusWidth-1:0] imem_inst,
  output logic                    out_valid,
  output logic [InstBusWidth-1:0] out_inst,
  output logic [InstAddrBus-1:0]  out_pc,
  input  logic                    out_ready,
  output logic                    busy
);

  import necpu_pkg::*;

  localparam int unsigned CntW   = $clog2(QDEPTH + 1);
  localparam int unsigned EntryW = InstAddrBus + InstBusWidth;

  fetch_state_e           state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [CntW-1:0]        q_count;
  logic [EntryW-1:0]      q_rdata;
  logic                   running, pop, push, flush;

  assign running   = (state_q == RUN);
  assign out_valid = (q_count != '0);
  assign pop       = out_valid && out_ready;
  // Any redirect, or a halt while running, empties the queue; flush overrides pop in the FIFO.
  assign flush     = redirect_valid || (running && halt);
  assign push      = running && !halt && !redirect_valid &&
                     ((q_count < CntW'(QDEPTH)) || pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (halt)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .Width (EntryW),
    .Depth (QDEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_q, imem_inst}),
    .rdata (q_rdata),
    .count (q_count)
  );

  assign imem_addr = pc_q;
  assign busy      = running;
  assign out_pc    = out_valid ? q_rdata[EntryW-1:InstBusWidth] : '0;
  assign out_inst  = out_valid ? q_rdata[InstBusWidth-1:0] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: stub instMem returns addr + 0x100; per-cycle vector table plus
// scoreboard-checked sequences for halt, wrap and asynchronous reset.
module tb_fetch_unit;

  localparam int unsigned IW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned QD = 2;
  localparam int          NV = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_inst;
  logic          out_valid;
  logic [IW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic          busy;

  always #5 clk = ~clk;

  assign imem_inst = imem_addr + 32'h100;

  fetch_unit #(
    .InstBusWidth (IW),
    .InstAddrBus  (AW),
    .QDEPTH       (QD),
    .RESET_PC     (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .busy           (busy)
  );

  typedef struct {
    logic        start;
    logic        halt;
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        ebusy;
  } vec_t;

  vec_t        vecs [NV];
  logic [31:0] sb [$];
  bit          sb_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // A handshake this cycle consumes the next expected PC; a redirect discards the pop.
  task automatic monitor();
    logic [31:0] exp;
    if (sb_en && out_valid && out_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc 0x%08h, expected no output", out_pc);
      end else begin
        exp = sb.pop_front();
        chk("sb_pc", out_pc, exp);
        chk("sb_inst", out_inst, exp + 32'h100);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      #1 monitor();
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic rv, input logic [31:0] rpc,
                       input logic r);
    start          = s;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = r;
  endtask

  initial begin
    //           start halt rv  rpc       rdy  ev   epc       eaddr     ebusy
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  32'h1,  1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  32'h2,  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  32'h2,  1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  32'h2,  1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h1,  32'h3,  1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h2,  32'h4,  1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h3,  32'h5,  1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h3,  32'h5,  1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h40, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 32'h41, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 32'h42, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 32'h42, 1'b1};

    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Start, backpressure, full hold, redirect over queued pc 3/4, start ignored in RUN.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].halt, vecs[i].rv, vecs[i].rpc, vecs[i].ready);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
      chk($sformatf("vec%0d_inst", i), out_inst,
          vecs[i].ev ? vecs[i].epc + 32'h100 : 32'h0);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
      @(negedge clk);
    end

    // Steady-state drain of the redirected stream: one entry per cycle, no bubbles.
    sb_en = 1'b1;
    for (int p = 'h40; p < 'h48; p++) sb.push_back(32'(p));
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(8);
    chk("steady_drained", 32'(sb.size()), 32'h0);

    // Halt together with redirect to 0x10, then restart from there.
    drive(1'b0, 1'b1, 1'b1, 32'h10, 1'b0);
    run(1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("halt_busy", 32'(busy), 32'h0);
    chk("halt_valid", 32'(out_valid), 32'h0);
    chk("halt_addr", imem_addr, 32'h10);
    @(negedge clk);
    #1;
    chk("idle_hold_valid", 32'(out_valid), 32'h0);
    chk("idle_hold_addr", imem_addr, 32'h10);
    @(negedge clk);
    sb.delete();
    sb.push_back(32'h10);
    sb.push_back(32'h11);
    sb.push_back(32'h12);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    run(1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("restart_lat_valid", 32'(out_valid), 32'h0);
    chk("restart_lat_busy", 32'(busy), 32'h1);
    @(negedge clk);
    run(3);
    out_ready = 1'b0;
    chk("restart_drained", 32'(sb.size()), 32'h0);

    // PC wrap past the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run(1);
    sb.delete();
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h0000_0000);
    sb.push_back(32'h0000_0001);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(4);
    out_ready = 1'b0;
    chk("wrap_drained", 32'(sb.size()), 32'h0);

    // Asynchronous reset between clock edges while streaming.
    sb_en = 1'b0;
    out_ready = 1'b1;
    run(3);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_inst", out_inst, 32'h0);
    chk("async_rst_pc", out_pc, 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    sb.push_back(32'h0);
    sb.push_back(32'h1);
    sb.push_back(32'h2);
    sb_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    run(1);
    start = 1'b0;
    #1;
    chk("post_rst_lat_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    run(3);
    out_ready = 1'b0;
    chk("post_rst_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
